// File: rtl/stdoaoi_pkg.sv
// rtl/stdoaoi_pkg.sv - shared constants for the stdoaoi complex-gate pipeline
package stdoaoi_pkg;

   localparam logic [1:0] MODE_OAOI211 = 2'd0;
   localparam logic [1:0] MODE_AOAI211 = 2'd1;
   localparam logic [1:0] MODE_AOI211  = 2'd2;
   localparam logic [1:0] MODE_OAI211  = 2'd3;

   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 4;

endpackage

// File: rtl/stdoaoi_fn.sv
// rtl/stdoaoi_fn.sv - bitwise selectable 4-input complex-gate function
module stdoaoi_fn
   import stdoaoi_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] IN0,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic [WIDTH-1:0] IN3,
   input  logic [1:0]       MODE,
   output logic [WIDTH-1:0] F
);

   always_comb begin
      F = '0;
      unique case (MODE)
         MODE_OAOI211: F = ~(((IN0 | IN1) & IN2) | IN3);
         MODE_AOAI211: F = ~(((IN0 & IN1) | IN2) & IN3);
         MODE_AOI211:  F = ~((IN0 & IN1) | IN2 | IN3);
         MODE_OAI211:  F = ~((IN0 | IN1) & IN2 & IN3);
         default:      F = '0;
      endcase
   end

endmodule

// File: rtl/stdoaoi_pipe.sv
// rtl/stdoaoi_pipe.sv - complex-gate function, valid/ready pipeline, saturating toggle counter
module stdoaoi_pipe
   import stdoaoi_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] IN0,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic [WIDTH-1:0] IN3,
   input  logic [1:0]       MODE,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] Y,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   input  logic             CNT_CLR,
   output logic [CNT_W-1:0] TOG_CNT
);

   if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("stdoaoi_pipe: STAGES must be within 1..4");
   end

   // Sum is wide enough that one add of a full-width popcount can never wrap.
   localparam int POP_W = $clog2(WIDTH + 1);
   localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [WIDTH-1:0]  w_f;
   logic [WIDTH-1:0]  r_d [STAGES];
   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] w_rdy;
   logic [WIDTH-1:0]  r_last_y;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  w_diff;
   logic [SUM_W-1:0]  w_sum;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_xfer;
   logic              w_acc;

   stdoaoi_fn #(.WIDTH(WIDTH)) u_fn (
      .IN0  (IN0),
      .IN1  (IN1),
      .IN2  (IN2),
      .IN3  (IN3),
      .MODE (MODE),
      .F    (w_f)
   );

   // A stage is ready when it or any stage downstream of it is empty, or the sink accepts.
   always_comb begin
      w_rdy = '0;
      w_acc = OUT_READY;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_acc    = w_acc | ~r_v[k];
         w_rdy[k] = w_acc;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_v <= '0;
         for (int k = 0; k < STAGES; k++) r_d[k] <= '0;
      end else begin
         if (w_rdy[0]) begin
            r_v[0] <= IN_VALID;
            r_d[0] <= w_f;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_v[k] <= r_v[k-1];
               r_d[k] <= r_d[k-1];
            end
         end
      end
   end

   assign w_xfer = r_v[STAGES-1] & OUT_READY;

   always_comb begin
      w_diff = r_d[STAGES-1] ^ r_last_y;
      w_sum  = {{(SUM_W-CNT_W){1'b0}}, r_cnt};
      for (int i = 0; i < WIDTH; i++) w_sum = w_sum + {{(SUM_W-1){1'b0}}, w_diff[i]};
      w_cnt_nxt = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt    <= '0;
         r_last_y <= '0;
      end else begin
         if (CNT_CLR)     r_cnt <= '0;
         else if (w_xfer) r_cnt <= w_cnt_nxt;
         if (w_xfer) r_last_y <= r_d[STAGES-1];
      end
   end

   assign IN_READY  = w_rdy[0];
   assign Y         = r_d[STAGES-1];
   assign OUT_VALID = r_v[STAGES-1];
   assign TOG_CNT   = r_cnt;

endmodule

// File: tb/tb_stdoaoi_pipe.sv
// tb/tb_stdoaoi_pipe.sv - scoreboard bench for stdoaoi_pipe (STAGES=2/CNT_W=16 and STAGES=1/CNT_W=4)
module tb_stdoaoi_pipe;

   logic       CLK;
   logic       RST_N;
   logic [7:0] in0 [2];
   logic [7:0] in1 [2];
   logic [7:0] in2 [2];
   logic [7:0] in3 [2];
   logic [1:0] mode [2];
   logic       iv [2];
   logic       ir [2];
   logic [7:0] y [2];
   logic       ov [2];
   logic       ordy [2];
   logic       clr [2];
   logic [15:0] tog_a;
   logic [3:0]  tog_b;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_mem [2][1024];
   int         head [2];
   int         tail [2];
   int         m_cnt [2];
   logic [7:0] m_last [2];
   logic       prev_stall [2];
   logic [7:0] prev_y [2];

   stdoaoi_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_a (
      .CLK(CLK), .RST_N(RST_N),
      .IN0(in0[0]), .IN1(in1[0]), .IN2(in2[0]), .IN3(in3[0]), .MODE(mode[0]),
      .IN_VALID(iv[0]), .IN_READY(ir[0]), .Y(y[0]), .OUT_VALID(ov[0]),
      .OUT_READY(ordy[0]), .CNT_CLR(clr[0]), .TOG_CNT(tog_a)
   );

   stdoaoi_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(4)) u_b (
      .CLK(CLK), .RST_N(RST_N),
      .IN0(in0[1]), .IN1(in1[1]), .IN2(in2[1]), .IN3(in3[1]), .MODE(mode[1]),
      .IN_VALID(iv[1]), .IN_READY(ir[1]), .Y(y[1]), .OUT_VALID(ov[1]),
      .OUT_READY(ordy[1]), .CNT_CLR(clr[1]), .TOG_CNT(tog_b)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [7:0] ref_f(input logic [1:0] m, input logic [7:0] a, b, c, d);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         case (m)
            2'd0: r[i] = !(((a[i] || b[i]) && c[i]) || d[i]);
            2'd1: r[i] = !(((a[i] && b[i]) || c[i]) && d[i]);
            2'd2: r[i] = !((a[i] && b[i]) || c[i] || d[i]);
            default: r[i] = !((a[i] || b[i]) && c[i] && d[i]);
         endcase
      end
      return r;
   endfunction

   // Scoreboard: records accepted inputs, checks every output transfer and the counter.
   initial begin
      forever begin
         @(negedge CLK);
         for (int u = 0; u < 2; u++) begin
            int          st;
            int          cm;
            int          occ;
            int          pop;
            logic [15:0] tg;
            st  = (u == 0) ? 2 : 1;
            cm  = (u == 0) ? 65535 : 15;
            tg  = (u == 0) ? tog_a : {12'd0, tog_b};
            occ = tail[u] - head[u];
            if (!RST_N) begin
               head[u] = 0; tail[u] = 0; m_cnt[u] = 0;
               m_last[u] = 8'h00; prev_stall[u] = 1'b0;
            end else begin
               chk("in_ready", ir[u], (occ == st && !ordy[u]) ? 0 : 1);
               chk("tog_cnt", tg, m_cnt[u]);
               if (prev_stall[u]) begin
                  chk("hold_valid", ov[u], 1);
                  chk("hold_y", y[u], prev_y[u]);
               end
               if (ov[u] && ordy[u]) begin
                  chk("out_expected", occ > 0, 1);
                  if (occ > 0) begin
                     chk("y_data", y[u], exp_mem[u][head[u] & 1023]);
                     head[u]++;
                  end
                  pop = $countones(y[u] ^ m_last[u]);
                  m_cnt[u]  = clr[u] ? 0 : ((m_cnt[u] + pop > cm) ? cm : m_cnt[u] + pop);
                  m_last[u] = y[u];
               end else if (clr[u]) begin
                  m_cnt[u] = 0;
               end
               prev_stall[u] = ov[u] && !ordy[u];
               prev_y[u]     = y[u];
               if (iv[u] && ir[u]) begin
                  exp_mem[u][tail[u] & 1023] = ref_f(mode[u], in0[u], in1[u], in2[u], in3[u]);
                  tail[u]++;
               end
            end
         end
      end
   end

   task automatic send(input int u, input logic [1:0] m, input logic [7:0] a, b, c, d);
      int t;
      mode[u] = m; in0[u] = a; in1[u] = b; in2[u] = c; in3[u] = d; iv[u] = 1'b1;
      t = 0;
      @(negedge CLK);
      while (!ir[u] && t < 50) begin
         @(negedge CLK);
         t++;
      end
      chk("send_ready", ir[u], 1);
      @(posedge CLK); #1;
      iv[u] = 1'b0;
   endtask

   task automatic lat(input int u, input int exp_edges);
      int n;
      n = 0;
      while (!ov[u] && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("latency", n, exp_edges);
   endtask

   task automatic drain(input int u);
      int t;
      t = 0;
      while (head[u] != tail[u] && t < 200) begin
         @(posedge CLK); #1;
         t++;
      end
      chk("drain_empty", head[u] == tail[u], 1);
   endtask

   task automatic rand_send(input int u);
      send(u, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   logic done_a, done_b;

   initial begin
      RST_N = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in0[u] = 0; in1[u] = 0; in2[u] = 0; in3[u] = 0; mode[u] = 0;
         iv[u] = 0; ordy[u] = 1; clr[u] = 0;
      end
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ov_a", ov[0], 0); chk("rst_y_a", y[0], 0); chk("rst_tog_a", tog_a, 0);
      chk("rst_ir_a", ir[0], 1); chk("rst_ov_b", ov[1], 0); chk("rst_ir_b", ir[1], 1);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      // single OAOI211 transaction
      send(0, 2'd0, 8'h0F, 8'h30, 8'h3C, 8'h80);
      lat(0, 1);
      chk("first_y", y[0], 8'h43);
      @(posedge CLK); #1;
      chk("one_cycle_valid", ov[0], 0);
      chk("first_tog", tog_a, 3);

      // remaining modes back to back
      send(0, 2'd1, 8'h0F, 8'h30, 8'h3C, 8'h80);
      send(0, 2'd2, 8'h0F, 8'h30, 8'h3C, 8'h80);
      send(0, 2'd3, 8'h0F, 8'h30, 8'h3C, 8'h80);
      drain(0);

      // 6-item stream with a 3-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 6; i++) rand_send(0);
         end
         begin
            repeat (2) @(posedge CLK);
            #1 ordy[0] = 1'b0;
            repeat (3) @(posedge CLK);
            #1 ordy[0] = 1'b1;
         end
      join
      drain(0);

      // saturation on the 4-bit counter, then clear coincident with a transfer
      send(1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00);
      send(1, 2'd2, 8'h00, 8'h00, 8'hFF, 8'h00);
      send(1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00);
      drain(1);
      @(posedge CLK); #1;
      chk("tog_saturated", tog_b, 15);
      clr[1] = 1'b1;
      send(1, 2'd2, 8'h00, 8'h00, 8'hFF, 8'h00);
      @(posedge CLK); #1;
      clr[1] = 1'b0;
      chk("tog_cleared", tog_b, 0);
      send(1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00);
      drain(1);
      @(posedge CLK); #1;
      chk("tog_after_clr", tog_b, 8);

      // asynchronous reset with both stages holding data
      ordy[0] = 1'b0;
      send(0, 2'd0, 8'h0F, 8'h30, 8'h3C, 8'h80);
      send(0, 2'd1, 8'h01, 8'h02, 8'h04, 8'h08);
      @(posedge CLK); #1;
      chk("pre_rst_full", ir[0], 0);
      #1 RST_N = 1'b0;
      #1;
      chk("async_ov", ov[0], 0); chk("async_y", y[0], 0); chk("async_tog", tog_a, 0);
      chk("async_ir", ir[0], 1);
      @(negedge CLK);
      @(posedge CLK); #2;
      RST_N = 1'b1;
      ordy[0] = 1'b1;
      @(posedge CLK); #1;
      send(0, 2'd2, 8'h11, 8'h22, 8'h44, 8'h08);
      lat(0, 1);
      drain(0);

      // randomized traffic on both instances
      done_a = 1'b0; done_b = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) rand_send(0);
            done_a = 1'b1;
         end
         begin
            for (int i = 0; i < 150; i++) rand_send(1);
            done_b = 1'b1;
         end
         begin
            int g;
            g = 0;
            while (!(done_a && done_b) && g < 5000) begin
               @(posedge CLK); #1;
               ordy[0] = ($urandom_range(0, 3) != 0);
               ordy[1] = ($urandom_range(0, 1) != 0);
               clr[0]  = ($urandom_range(0, 31) == 0);
               clr[1]  = ($urandom_range(0, 15) == 0);
               g++;
            end
            ordy[0] = 1'b1; ordy[1] = 1'b1; clr[0] = 1'b0; clr[1] = 1'b0;
         end
      join
      drain(0);
      drain(1);
      repeat (2) @(posedge CLK);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
